dm_lsu: RTL and testbench
=========================

# dm_lsu

Load/store unit that acts as the initiator for the 1024×32 word-addressed data memory. It accepts byte-addressed load/store requests from the CPU datapath, and handles byte and halfword granularity: sub-word loads are extracted and extended, and sub-word stores use a read-modify-write sequence. It sits between the EX/MEM stage and the data memory, which has a combinational read port and a write port sampled on the rising clock edge.

## Interface
- ADDR_W, 10, word-address width driven to the data memory (4 KiB space)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  request strobe, sampled only when busy=0
- we  in  1  1=store, 0=load
- size  in  2  00=byte, 01=halfword, 10=word, 11=illegal
- sext  in  1  loads only: 1=sign-extend, 0=zero-extend
- addr  in  32  byte address; bits above [ADDR_W+1] ignored (wrap modulo 4 KiB)
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- busy  out  1  high while a request is in flight (any state but IDLE)
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned or illegal size, no memory effect
- rdata  out  32  load result, held until the next successful load completes
- dm_addr  out  ADDR_W  word address = latched addr[ADDR_W+1:2]
- dm_din  out  32  merged write word
- dm_we  out  1  memory write enable
- dm_dout  in  32  memory read data (combinational from dm_addr)

## Operation
- States: IDLE, LOAD, RMW_RD, WRITE, DONE.
- IDLE: on req=1, latch we/size/sext/addr/wdata. Next state:
  - illegal size, half with addr[0]=1, or word with addr[1:0]≠0 → DONE with err=1
  - load → LOAD
  - word store → WRITE
  - byte or half store → RMW_RD
- LOAD: capture dm_dout, select lane, extend per sext into rdata → DONE.
- RMW_RD: capture dm_dout into merge register with the target lane(s) replaced by wdata → WRITE.
- WRITE: dm_we=1, dm_din=merge register (word store: wdata) → DONE.
- DONE: done=1 (err as latched) → IDLE. A new req is not accepted in this cycle.
- Lanes are little-endian:
  - byte: addr[1:0]=0 → [7:0] … 3 → [31:24]
  - half: addr[1]=0 → [15:0], 1 → [31:16]
- req while busy=1 is ignored, not queued.
- dm_we is decoded only from state==WRITE, with no other term.
- dm_addr in IDLE follows the live addr input. In all other states it follows the latched address.

## Timing
- Reset values: state IDLE; busy=0, done=0, err=0, rdata=0, dm_we=0, dm_din=0, merge register=0.
- Latency from the edge where req is sampled (E0) to done high:
  - load: 2 cycles (LOAD, DONE)
  - word store: 2 cycles; memory is written at E1
  - sub-word store: 3 cycles; memory is written at E2
  - error: 1 cycle
- rdata updates at the edge leaving LOAD and is valid while done=1.
- Reset mid-operation: the state returns to IDLE immediately. If this happens in WRITE, dm_we falls before the next edge, so no memory write occurs. No done pulse follows reset.
- Back-to-back requests: the minimum issue interval is latency+1 cycles, because IDLE must be revisited.

## Structure
- Package dm_pkg holds:
  - the size encodings (SZ_B, SZ_H, SZ_W)
  - the state enumeration
  - ADDR_W default
- Sub-module dm_lane is purely combinational and has two functions:
  - load-extract/extend: dm_dout, addr[1:0], size, sext → word
  - store-merge: old word, wdata, addr[1:0], size → word
- The top level contains the FSM, the latches, and the memory-side drive.

## Test plan
- Word store then load: store 0xDEADBEEF at addr 0x10 → dm_we high for 1 cycle with dm_addr=4; a following load word returns rdata=0xDEADBEEF, done 2 cycles after req.
- Byte store RMW: memory word 1 holds 0x11223344; store byte 0xAA at addr 0x06 → dm_we asserted in the 2nd cycle with dm_din=0x11AA3344, done 3 cycles after req.
- Sign/zero extension: word 0 holds 0x80FF7F01:
  - lb addr 0x02 sext=1 → 0xFFFFFFFF
  - lbu addr 0x03 → 0x00000080
  - lh addr 0x02 sext=1 → 0xFFFF80FF
  - lhu addr 0x00 → 0x00007F01
- Misalignment and illegal size: lw addr 0x02, sh addr 0x01, size=11 → each gives done=1 with err=1 one cycle after req, dm_we never high, memory unchanged.
- Reset in WRITE during a byte store → dm_we drops at once; the memory word is unchanged; busy=0, done=0, rdata=0 after reset.
- req pulsed while busy plus address wrap: a second req during LOAD is ignored (exactly one done pulse); a store to addr 0x1004 writes dm_addr=1.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory load/store unit: size codes, FSM states and
// the default word-address width.
package dm_pkg;

  localparam int unsigned DEF_ADDR_W = 10;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRmwRd,
    StWrite,
    StDone
  } state_t;

endpackage

// File: rtl/dm_lane.sv
// Little-endian lane steering: extracts/extends sub-word loads and merges sub-word store
// data into an existing memory word.
module dm_lane import dm_pkg::*; (
  input  logic [31:0] dout,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_word,
  output logic [31:0] merge_word
);

  logic [4:0]  b_sh;
  logic [4:0]  h_sh;
  logic [31:0] b_val;
  logic [31:0] h_val;
  logic [31:0] b_mask;
  logic [31:0] h_mask;

  // Halfword lanes are selected by off[1] alone; alignment is checked upstream.
  assign b_sh   = {off, 3'b000};
  assign h_sh   = {off[1], 4'b0000};
  assign b_val  = dout >> b_sh;
  assign h_val  = dout >> h_sh;
  assign b_mask = 32'h0000_00ff << b_sh;
  assign h_mask = 32'h0000_ffff << h_sh;

  always_comb begin
    load_word  = dout;
    merge_word = wdata;
    case (size)
      SZ_B: begin
        load_word  = {{24{sext & b_val[7]}}, b_val[7:0]};
        merge_word = (old_word & ~b_mask) | ({24'h0, wdata[7:0]} << b_sh);
      end
      SZ_H: begin
        load_word  = {{16{sext & h_val[15]}}, h_val[15:0]};
        merge_word = (old_word & ~h_mask) | ({16'h0, wdata[15:0]} << h_sh);
      end
      default: begin
        load_word  = dout;
        merge_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/dm_lsu.sv
// Load/store unit driving a word-addressed data memory; sub-word stores are done as
// read-modify-write, sub-word loads are extracted and extended.
module dm_lsu import dm_pkg::*; #(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);

  state_t          state_q;
  logic [1:0]      size_q;
  logic            sext_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]     wdata_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic [31:0]     merge_q;

  logic [31:0]     load_word;
  logic [31:0]     merge_word;
  logic            bad_req;
  logic            unused_addr;

  // Address bits beyond the 4 KiB window are ignored, giving wrap-around.
  assign unused_addr = ^addr[31:ADDR_W+2];

  assign bad_req = (size == 2'b11) ||
                   ((size == SZ_H) && addr[0]) ||
                   ((size == SZ_W) && (addr[1:0] != 2'b00));

  dm_lane u_lane (
    .dout       (dm_dout),
    .off        (addr_q[1:0]),
    .size       (size_q),
    .sext       (sext_q),
    .old_word   (dm_dout),
    .wdata      (wdata_q),
    .load_word  (load_word),
    .merge_word (merge_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      size_q  <= SZ_B;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      merge_q <= 32'h0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            size_q  <= size;
            sext_q  <= sext;
            addr_q  <= addr[ADDR_W+1:0];
            wdata_q <= wdata;
            err_q   <= bad_req;
            if (bad_req) begin
              state_q <= StDone;
            end else if (!we) begin
              state_q <= StLoad;
            end else if (size == SZ_W) begin
              merge_q <= wdata;
              state_q <= StWrite;
            end else begin
              state_q <= StRmwRd;
            end
          end
        end
        StLoad: begin
          rdata_q <= load_word;
          state_q <= StDone;
        end
        StRmwRd: begin
          merge_q <= merge_word;
          state_q <= StWrite;
        end
        StWrite: state_q <= StDone;
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign err     = done & err_q;
  assign rdata   = rdata_q;
  assign dm_we   = (state_q == StWrite);
  assign dm_din  = merge_q;
  assign dm_addr = (state_q == StIdle) ? addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu: issued requests push expectations, a monitor checks each
// done pulse against them; a behavioural 1024x32 memory sits on the memory port.
module tb_dm_lsu;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;

  logic [31:0] mem [1024];

  typedef struct {
    int          due;
    logic        err;
    logic        chk;
    logic [31:0] rd;
    string       nm;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          issue_cyc = 0;
  int          wr_cnt = 0;
  int          wr_cyc = 0;
  logic [9:0]  wr_addr;
  logic [31:0] wr_din;

  dm_lsu #(.ADDR_W(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .we      (we),
    .size    (size),
    .sext    (sext),
    .addr    (addr),
    .wdata   (wdata),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .rdata   (rdata),
    .dm_addr (dm_addr),
    .dm_din  (dm_din),
    .dm_we   (dm_we),
    .dm_dout (dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];
  always @(posedge clk) if (dm_we) mem[dm_addr] <= dm_din;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Memory-write logger
  always @(negedge clk) begin
    if (dm_we) begin
      wr_cnt  = wr_cnt + 1;
      wr_cyc  = cyc;
      wr_addr = dm_addr;
      wr_din  = dm_din;
    end
  end

  // Completion monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got done=1, expected no completion");
      end else begin
        e = sb.pop_front();
        check({e.nm, "_lat"}, cyc, e.due);
        check({e.nm, "_err"}, {31'h0, err}, {31'h0, e.err});
        if (e.chk) check({e.nm, "_rdata"}, rdata, e.rd);
      end
    end
  end

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 16 && busy; i++) @(negedge clk);
    check({nm, "_idle"}, {31'h0, busy}, 32'h0);
    check({nm, "_drained"}, sb.size(), 32'h0);
  endtask

  task automatic issue(input string nm, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic e_err,
                       input logic e_chk, input logic [31:0] e_rd, input int lat);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    issue_cyc = cyc;
    sb.push_back('{due: cyc + lat, err: e_err, chk: e_chk, rd: e_rd, nm: nm});
    @(negedge clk);
    req = 1'b0;
    wait_idle(nm);
  endtask

  int          wc0;
  logic [31:0] m0;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b10; sext = 1'b0;
    addr = 32'h0000_1008; wdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_dm_we", {31'h0, dm_we}, 32'h0);
    check("rst_dm_din", dm_din, 32'h0);
    check("idle_dm_addr_live", {22'h0, dm_addr}, 32'h2);
    rst = 1'b0;
    @(negedge clk);

    // Word store then load
    wc0 = wr_cnt;
    issue("sw_beef", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 2);
    check("sw_beef_wcnt", wr_cnt - wc0, 32'd1);
    check("sw_beef_waddr", {22'h0, wr_addr}, 32'h4);
    check("sw_beef_wdin", wr_din, 32'hDEADBEEF);
    check("sw_beef_wcyc", wr_cyc - issue_cyc, 32'd1);
    issue("lw_beef", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 2);

    // Byte store read-modify-write
    issue("sw_w1", 1'b1, 2'b10, 1'b0, 32'h04, 32'h11223344, 1'b0, 1'b0, 32'h0, 2);
    wc0 = wr_cnt;
    issue("sb_aa", 1'b1, 2'b00, 1'b0, 32'h06, 32'hFFFF_FFAA, 1'b0, 1'b0, 32'h0, 3);
    check("sb_aa_wcnt", wr_cnt - wc0, 32'd1);
    check("sb_aa_wdin", wr_din, 32'h11AA3344);
    check("sb_aa_wcyc", wr_cyc - issue_cyc, 32'd2);
    check("sb_aa_mem", mem[1], 32'h11AA3344);

    // Halfword store into upper lane of word 4
    issue("sh_hi", 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD_1234, 1'b0, 1'b0, 32'h0, 3);
    check("sh_hi_mem", mem[4], 32'h1234BEEF);

    // Extension
    issue("sw_w0", 1'b1, 2'b10, 1'b0, 32'h00, 32'h80FF7F01, 1'b0, 1'b0, 32'h0, 2);
    issue("lb_s", 1'b0, 2'b00, 1'b1, 32'h02, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 2);
    issue("lbu", 1'b0, 2'b00, 1'b0, 32'h03, 32'h0, 1'b0, 1'b1, 32'h00000080, 2);
    issue("lh_s", 1'b0, 2'b01, 1'b1, 32'h02, 32'h0, 1'b0, 1'b1, 32'hFFFF80FF, 2);
    issue("lhu", 1'b0, 2'b01, 1'b0, 32'h00, 32'h0, 1'b0, 1'b1, 32'h00007F01, 2);
    issue("lb_s_pos", 1'b0, 2'b00, 1'b1, 32'h00, 32'h0, 1'b0, 1'b1, 32'h00000001, 2);

    // Misaligned and illegal: rdata must hold the last good load value
    wc0 = wr_cnt;
    m0  = mem[0];
    issue("lw_mis", 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1'b1, 1'b1, 32'h00000001, 1);
    issue("sh_mis", 1'b1, 2'b01, 1'b0, 32'h01, 32'h5555, 1'b1, 1'b0, 32'h0, 1);
    issue("sz_ill", 1'b1, 2'b11, 1'b0, 32'h00, 32'h5555, 1'b1, 1'b0, 32'h0, 1);
    check("err_no_write", wr_cnt - wc0, 32'd0);
    check("err_mem0", mem[0], m0);

    // Reset while in WRITE of a byte store
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h05; wdata = 32'h55;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rstw_pre_we", {31'h0, dm_we}, 32'h1);
    rst = 1'b1;
    #1;
    check("rstw_we", {31'h0, dm_we}, 32'h0);
    check("rstw_busy", {31'h0, busy}, 32'h0);
    check("rstw_done", {31'h0, done}, 32'h0);
    check("rstw_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rstw_mem1", mem[1], 32'h11AA3344);

    // Request while busy is ignored
    wc0 = wr_cnt;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sext = 1'b0; addr = 32'h10;
    sb.push_back('{due: cyc + 2, err: 1'b0, chk: 1'b1, rd: 32'h1234BEEF, nm: "lw_busy"});
    @(negedge clk);
    we = 1'b1; addr = 32'h14; wdata = 32'hCAFEF00D;
    #1;
    check("busy_dm_addr_latched", {22'h0, dm_addr}, 32'h4);
    @(negedge clk);
    req = 1'b0;
    wait_idle("lw_busy");
    repeat (4) @(negedge clk);
    check("busy_no_write", wr_cnt - wc0, 32'd0);

    // Address wrap
    issue("sw_wrap", 1'b1, 2'b10, 1'b0, 32'h1004, 32'h12345678, 1'b0, 1'b0, 32'h0, 2);
    check("wrap_waddr", {22'h0, wr_addr}, 32'h1);
    check("wrap_mem1", mem[1], 32'h12345678);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
